snn_readout_ctrl: RTL and testbench

//  Sequences the SNN output-layer readout.
//  - Accumulates per-timestep class logits (3 classes) over NUM_STEPS timesteps.
//  - Issues the summed vector to the downstream argmax unit over a valid/ready handshake.
//  - Collects the 2-bit predicted class and presents it on a result handshake.
//  - Sits between the final spiking layer and the argmax classifier; the argmax itself is external.
//

---
 rtl/snn_readout_if.sv | 29 ++
 rtl/snn_readout_ctrl.sv | 110 +++++++++++
 tb/tb_snn_readout_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/snn_readout_if.sv
// Handshake bundle between the SNN readout controller, the argmax unit and the result consumer.
interface snn_readout_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32
);
  logic                    i_valid;
  logic                    i_ready;
  logic [3*DATA_WIDTH-1:0] i_logits;
  logic                    am_valid;
  logic                    am_ready;
  logic [3*ACC_WIDTH-1:0]  am_logits;
  logic                    am_o_valid;
  logic                    am_o_ready;
  logic [1:0]              am_class;
  logic                    o_valid;
  logic                    o_ready;
  logic [1:0]              o_class;
  logic                    o_busy;

  modport slave (
    input  i_valid, i_logits, am_ready, am_o_valid, am_class, o_ready,
    output i_ready, am_valid, am_logits, am_o_ready, o_valid, o_class, o_busy
  );

  modport master (
    output i_valid, i_logits, am_ready, am_o_valid, am_class, o_ready,
    input  i_ready, am_valid, am_logits, am_o_ready, o_valid, o_class, o_busy
  );
endinterface

// File: rtl/snn_readout_ctrl.sv
// SNN output-layer readout: sums 3 class logits over NUM_STEPS, hands them to argmax, returns the class.
// Optional macro SNN_READOUT_SAT_EN: saturating (sticky) accumulation instead of wrap-around.
module snn_readout_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_STEPS  = 8,
  parameter int STEP_W     = $clog2(NUM_STEPS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  snn_readout_if.slave  bus
);
  typedef enum logic [1:0] {S_ACC, S_ISSUE, S_WAIT, S_OUT} state_e;

  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  state_e                         state_q, state_d;
  logic [STEP_W-1:0]              step_q, step_d;
  logic [2:0][ACC_WIDTH-1:0]      acc_q, acc_d, upd;
  logic [1:0]                     class_q, class_d;
  logic                           first;

  assign first = (step_q == '0);

`ifdef SNN_READOUT_SAT_EN
  logic [2:0] sat_q, sat_d, sat_nx;
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`endif

  for (genvar k = 0; k < 3; k++) begin : g_cls
    logic signed [DATA_WIDTH-1:0] lg;
    logic signed [ACC_WIDTH-1:0]  ext;
    assign lg  = bus.i_logits[k*DATA_WIDTH +: DATA_WIDTH];
    assign ext = ACC_WIDTH'(lg);
`ifdef SNN_READOUT_SAT_EN
    // One guard bit detects overflow; once clipped the lane ignores further beats this frame.
    logic signed [ACC_WIDTH:0] wide;
    logic                      ovf;
    assign wide = (ACC_WIDTH+1)'(signed'(acc_q[k])) + (ACC_WIDTH+1)'(ext);
    assign ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
    assign sat_nx[k] = first ? 1'b0 : (sat_q[k] | ovf);
    assign upd[k] = first    ? ext :
                    sat_q[k] ? acc_q[k] :
                    ovf      ? (wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX) :
                               wide[ACC_WIDTH-1:0];
`else
    assign upd[k] = first ? ext : acc_q[k] + ext;
`endif
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    class_d = class_q;
`ifdef SNN_READOUT_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      S_ACC: if (bus.i_valid) begin
        acc_d = upd;
`ifdef SNN_READOUT_SAT_EN
        sat_d = sat_nx;
`endif
        if (step_q == LAST) begin
          step_d  = '0;
          state_d = S_ISSUE;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      S_ISSUE: if (bus.am_ready) state_d = S_WAIT;
      S_WAIT: if (bus.am_o_valid) begin
        class_d = bus.am_class;
        state_d = S_OUT;
      end
      S_OUT: if (bus.o_ready) state_d = S_ACC;
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      step_q  <= '0;
      acc_q   <= '0;
      class_q <= '0;
`ifdef SNN_READOUT_SAT_EN
      sat_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      class_q <= class_d;
`ifdef SNN_READOUT_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.i_ready    = (state_q == S_ACC);
  assign bus.am_valid   = (state_q == S_ISSUE);
  assign bus.am_o_ready = (state_q == S_WAIT);
  assign bus.o_valid    = (state_q == S_OUT);
  assign bus.am_logits  = {acc_q[2], acc_q[1], acc_q[0]};
  assign bus.o_class    = class_q;
  assign bus.o_busy     = (step_q != '0) || (state_q != S_ACC);
endmodule

// File: tb/tb_snn_readout_ctrl.sv
// Directed bench: 32-bit 4-step readout for frame/handshake/reset cases, 8-bit instance for overflow.
module tb_snn_readout_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  snn_readout_if #(.DATA_WIDTH(32), .ACC_WIDTH(32)) b32 ();
  snn_readout_if #(.DATA_WIDTH(8),  .ACC_WIDTH(8))  b8  ();

  snn_readout_ctrl #(.DATA_WIDTH(32), .ACC_WIDTH(32), .NUM_STEPS(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .bus(b32)
  );
  snn_readout_ctrl #(.DATA_WIDTH(8), .ACC_WIDTH(8), .NUM_STEPS(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(b8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] l0, l1, l2, e0, e1, e2,
                           input logic [1:0] cls, input int hold);
    b32.i_logits = {l2, l1, l0};
    b32.i_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("i_ready_acc", 32'(b32.i_ready), 32'd1);
      tick();
    end
    b32.i_valid = 1'b0;
    chk("am_valid", 32'(b32.am_valid), 32'd1);
    chk("am_logit0", b32.am_logits[31:0], e0);
    chk("am_logit1", b32.am_logits[63:32], e1);
    chk("am_logit2", b32.am_logits[95:64], e2);
    chk("i_ready_issue", 32'(b32.i_ready), 32'd0);
    chk("busy_issue", 32'(b32.o_busy), 32'd1);
    tick();
    chk("am_valid_hold", 32'(b32.am_valid), 32'd1);
    chk("am_logit0_hold", b32.am_logits[31:0], e0);
    b32.am_ready = 1'b1;
    tick();
    b32.am_ready = 1'b0;
    chk("am_o_ready", 32'(b32.am_o_ready), 32'd1);
    chk("am_valid_wait", 32'(b32.am_valid), 32'd0);
    b32.am_o_valid = 1'b1;
    b32.am_class   = cls;
    tick();
    b32.am_o_valid = 1'b0;
    b32.am_class   = 2'd3;
    chk("o_valid", 32'(b32.o_valid), 32'd1);
    chk("o_class", 32'(b32.o_class), 32'(cls));
    b32.o_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      b32.i_valid  = 1'b1;
      b32.i_logits = {32'd50, 32'd60, 32'd70};
      tick();
      chk("o_valid_stall", 32'(b32.o_valid), 32'd1);
      chk("o_class_stall", 32'(b32.o_class), 32'(cls));
      chk("i_ready_stall", 32'(b32.i_ready), 32'd0);
    end
    b32.i_valid = 1'b0;
    b32.o_ready = 1'b1;
    tick();
    b32.o_ready = 1'b0;
    chk("o_valid_done", 32'(b32.o_valid), 32'd0);
    chk("i_ready_done", 32'(b32.i_ready), 32'd1);
    chk("busy_done", 32'(b32.o_busy), 32'd0);
  endtask

  initial begin
    b32.i_valid = 1'b0; b32.i_logits = '0; b32.am_ready = 1'b0;
    b32.am_o_valid = 1'b0; b32.am_class = 2'd0; b32.o_ready = 1'b0;
    b8.i_valid = 1'b0; b8.i_logits = '0; b8.am_ready = 1'b0;
    b8.am_o_valid = 1'b0; b8.am_class = 2'd0; b8.o_ready = 1'b0;

    #12;
    chk("rst_i_ready", 32'(b32.i_ready), 32'd1);
    chk("rst_am_valid", 32'(b32.am_valid), 32'd0);
    chk("rst_am_o_ready", 32'(b32.am_o_ready), 32'd0);
    chk("rst_o_valid", 32'(b32.o_valid), 32'd0);
    chk("rst_o_class", 32'(b32.o_class), 32'd0);
    chk("rst_busy", 32'(b32.o_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // (1,5,2)x4, tie (7,7,7)x4, negatives (-3,-1,-7)x4
    run_frame(32'd1, 32'd5, 32'd2, 32'd4, 32'd20, 32'd8, 2'd1, 0);
    run_frame(32'd7, 32'd7, 32'd7, 32'd28, 32'd28, 32'd28, 2'd0, 0);
    run_frame(-32'sd3, -32'sd1, -32'sd7, -32'sd12, -32'sd4, -32'sd28, 2'd1, 0);
    // 10-cycle stall in OUT, then a frame proving stalled beats were ignored
    run_frame(32'd3, 32'd0, 32'd1, 32'd12, 32'd0, 32'd4, 2'd0, 10);
    run_frame(32'd1, 32'd5, 32'd2, 32'd4, 32'd20, 32'd8, 2'd1, 0);

    // 8-bit accumulation of 100 x4
    b8.i_logits = {8'd0, 8'd0, 8'd100};
    b8.i_valid  = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    b8.i_valid = 1'b0;
    chk("n8_am_valid", 32'(b8.am_valid), 32'd1);
`ifdef SNN_READOUT_SAT_EN
    chk("n8_acc0_sat", 32'(b8.am_logits[7:0]), 32'h7f);
`else
    chk("n8_acc0_wrap", 32'(b8.am_logits[7:0]), 32'h90);
`endif
    chk("n8_acc1", 32'(b8.am_logits[15:8]), 32'd0);

    // reset mid-frame after 2 beats
    b32.i_logits = {32'd9, 32'd9, 32'd9};
    b32.i_valid  = 1'b1;
    tick();
    tick();
    b32.i_valid = 1'b0;
    chk("mid_busy", 32'(b32.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(b32.o_busy), 32'd0);
    chk("mid_rst_i_ready", 32'(b32.i_ready), 32'd1);
    chk("mid_rst_acc0", b32.am_logits[31:0], 32'd0);
    chk("mid_rst_o_valid", 32'(b32.o_valid), 32'd0);
    chk("mid_rst_n8_am_valid", 32'(b8.am_valid), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    run_frame(32'd2, 32'd1, 32'd0, 32'd8, 32'd4, 32'd0, 2'd0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
